// File: rtl/memtrace_lane_issuer.sv
// Trace-line issuer: buffers one reader line, issues each valid lane
// as an independent request with a per-lane in-flight source ID.
module memtrace_lane_issuer #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8,
  parameter int SOURCE_WIDTH  = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic [63:0]                        trace_read_cycle,
  output logic                               trace_read_ready,
  input  logic [NUM_LANES-1:0]               trace_read_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_read_address,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    trace_read_data,
  input  logic [NUM_LANES-1:0]               trace_read_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_read_size,
  input  logic                               trace_read_finished,
  output logic [NUM_LANES-1:0]               a_valid,
  input  logic [NUM_LANES-1:0]               a_ready,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
  output logic [NUM_LANES-1:0]               a_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
  output logic [SOURCE_WIDTH*NUM_LANES-1:0]  a_source,
  input  logic [NUM_LANES-1:0]               d_valid,
  input  logic [SOURCE_WIDTH*NUM_LANES-1:0]  d_source,
  output logic [NUM_LANES-1:0]               d_ready,
  output logic                               done,
  output logic                               error
);

  localparam int NS = 1 << SOURCE_WIDTH;

  typedef enum logic [2:0] {
    FETCH, CAPTURE, ISSUE, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_LANES-1:0]    pending, pending_nxt;
  logic [NUM_LANES-1:0]    fire, has_free;
  logic [NS-1:0]           inflight     [NUM_LANES];
  logic [NS-1:0]           inflight_nxt [NUM_LANES];
  logic [SOURCE_WIDTH-1:0] free_id      [NUM_LANES];
  logic                    err_hit;
  logic                    idle_nxt;
  logic                    fin_q;
  logic [63:0]             cycle_q;

  logic [DATA_WIDTH*NUM_LANES-1:0]    addr_q, data_q;
  logic [NUM_LANES-1:0]               store_q;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] size_q;

  assign d_ready          = '1;
  assign done             = (state == DONE);
  assign trace_read_cycle = cycle_q;
  assign trace_read_ready = (state == FETCH) && !reset;
  assign a_address        = addr_q;
  assign a_data           = data_q;
  assign a_is_store       = store_q;
  assign a_size           = size_q;
  assign fire             = a_valid & a_ready;

  // Lowest clear bit of the registered bitmap is the offered ID.
  always_comb begin
    a_source = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      free_id[l] = '0;
      for (int i = NS - 1; i >= 0; i--) begin
        if (!inflight[l][i]) free_id[l] = SOURCE_WIDTH'(i);
      end
      has_free[l] = ~&inflight[l];
      a_source[l*SOURCE_WIDTH +: SOURCE_WIDTH] = free_id[l];
    end
  end

  always_comb begin
    a_valid = '0;
    if (state == ISSUE) a_valid = pending & has_free;
  end

  // Stray frees leave the bitmap alone; allocation still applies.
  always_comb begin
    err_hit  = 1'b0;
    idle_nxt = 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      inflight_nxt[l] = inflight[l];
      if (d_valid[l]) begin
        if (inflight[l][d_source[l*SOURCE_WIDTH +: SOURCE_WIDTH]])
          inflight_nxt[l][d_source[l*SOURCE_WIDTH +: SOURCE_WIDTH]] = 1'b0;
        else
          err_hit = 1'b1;
      end
      if (fire[l]) inflight_nxt[l][free_id[l]] = 1'b1;
      if (|inflight_nxt[l]) idle_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    unique case (state)
      FETCH: state_nxt = CAPTURE;
      CAPTURE: begin
        pending_nxt = trace_read_valid;
        if (|trace_read_valid)       state_nxt = ISSUE;
        else if (trace_read_finished) state_nxt = DRAIN;
        else                          state_nxt = FETCH;
      end
      ISSUE: begin
        pending_nxt = pending & ~fire;
        if (pending_nxt == '0) state_nxt = fin_q ? DRAIN : FETCH;
      end
      DRAIN: if (idle_nxt) state_nxt = DONE;
      DONE:  state_nxt = DONE;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      pending  <= '0;
      inflight <= '{default: '0};
      cycle_q  <= '0;
      error    <= 1'b0;
      fin_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      store_q  <= '0;
      size_q   <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      inflight <= inflight_nxt;
      cycle_q  <= cycle_q + 64'd1;
      if (err_hit) error <= 1'b1;
      if (state == CAPTURE) begin
        addr_q  <= trace_read_address;
        data_q  <= trace_read_data;
        store_q <= trace_read_is_store;
        size_q  <= trace_read_size;
        fin_q   <= trace_read_finished;
      end
    end
  end

endmodule

// File: tb/tb_memtrace_lane_issuer.sv
// Directed bench for memtrace_lane_issuer: issue timing, back-pressure,
// source exhaustion, stray responses, mid-issue reset and drain/done.
module tb_memtrace_lane_issuer;

  logic         clock = 1'b0;
  logic         reset;
  logic [63:0]  trace_read_cycle;
  logic         trace_read_ready;
  logic [3:0]   trace_read_valid;
  logic [255:0] trace_read_address;
  logic [255:0] trace_read_data;
  logic [3:0]   trace_read_is_store;
  logic [31:0]  trace_read_size;
  logic         trace_read_finished;
  logic [3:0]   a_valid;
  logic [3:0]   a_ready;
  logic [255:0] a_address;
  logic [255:0] a_data;
  logic [3:0]   a_is_store;
  logic [31:0]  a_size;
  logic [11:0]  a_source;
  logic [3:0]   d_valid;
  logic [11:0]  d_source;
  logic [3:0]   d_ready;
  logic         done;
  logic         error;

  int checks = 0;
  int errors = 0;

  memtrace_lane_issuer dut (
    .clock(clock), .reset(reset),
    .trace_read_cycle(trace_read_cycle),
    .trace_read_ready(trace_read_ready),
    .trace_read_valid(trace_read_valid),
    .trace_read_address(trace_read_address),
    .trace_read_data(trace_read_data),
    .trace_read_is_store(trace_read_is_store),
    .trace_read_size(trace_read_size),
    .trace_read_finished(trace_read_finished),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_address(a_address), .a_data(a_data),
    .a_is_store(a_is_store), .a_size(a_size),
    .a_source(a_source),
    .d_valid(d_valid), .d_source(d_source),
    .d_ready(d_ready), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_lane(input int l, input logic [63:0] addr,
                          input logic [63:0] data, input logic st,
                          input logic [7:0] sz);
    trace_read_address[l*64 +: 64] = addr;
    trace_read_data[l*64 +: 64]    = data;
    trace_read_is_store[l]         = st;
    trace_read_size[l*8 +: 8]      = sz;
  endtask

  initial begin
    reset = 1'b1;
    trace_read_valid = '0;
    trace_read_address = '0;
    trace_read_data = '0;
    trace_read_is_store = '0;
    trace_read_size = '0;
    trace_read_finished = 1'b0;
    a_ready = '0;
    d_valid = '0;
    d_source = '0;
    step();
    step();
    chk("rst_ready", 64'(trace_read_ready), 64'd0);
    chk("rst_cycle", trace_read_cycle, 64'd0);
    chk("rst_avalid", 64'(a_valid), 64'd0);
    chk("rst_addr", a_address[63:0], 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_dready", 64'(d_ready), 64'hf);

    // Single line, lanes 0 and 2
    trace_read_valid = 4'b0101;
    set_lane(0, 64'h1000, 64'hAAAA, 1'b0, 8'd3);
    set_lane(2, 64'h3000, 64'hCCCC, 1'b1, 8'd2);
    a_ready = 4'hf;
    reset = 1'b0;
    #1;
    chk("c1_ready", 64'(trace_read_ready), 64'd1);
    chk("c1_cycle", trace_read_cycle, 64'd0);
    step();
    chk("c2_ready", 64'(trace_read_ready), 64'd0);
    chk("c2_avalid", 64'(a_valid), 64'd0);
    chk("c2_cycle", trace_read_cycle, 64'd1);
    step();
    chk("c3_avalid", 64'(a_valid), 64'h5);
    chk("c3_src", 64'(a_source), 64'd0);
    chk("c3_addr0", a_address[63:0], 64'h1000);
    chk("c3_addr2", a_address[191:128], 64'h3000);
    chk("c3_data2", a_data[191:128], 64'hCCCC);
    chk("c3_store", 64'(a_is_store), 64'h4);
    chk("c3_size0", 64'(a_size[7:0]), 64'd3);
    chk("c3_cycle", trace_read_cycle, 64'd2);
    step();
    chk("c4_ready", 64'(trace_read_ready), 64'd1);
    chk("c4_avalid", 64'(a_valid), 64'd0);

    // Back-pressure on lane 1; free lanes 0/2 source 0
    d_valid = 4'b0101;
    d_source = '0;
    trace_read_valid = 4'b0010;
    set_lane(1, 64'h2222, 64'hBBBB, 1'b0, 8'd1);
    a_ready = 4'b1101;
    step();
    d_valid = '0;
    chk("bp_cap_err", 64'(error), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_avalid", 64'(a_valid), 64'h2);
      chk("bp_addr1", a_address[127:64], 64'h2222);
      chk("bp_src1", 64'(a_source[5:3]), 64'd0);
      chk("bp_ready", 64'(trace_read_ready), 64'd0);
    end
    a_ready = 4'hf;
    step();
    chk("bp_fetch", 64'(trace_read_ready), 64'd1);

    // Source exhaustion on lane 0
    trace_read_valid = 4'b0001;
    set_lane(0, 64'h40, 64'h1, 1'b0, 8'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      step();
      chk("ex_avalid", 64'(a_valid), 64'h1);
      chk("ex_src", 64'(a_source[2:0]), 64'(k));
      step();
      chk("ex_fetch", 64'(trace_read_ready), 64'd1);
    end
    step();
    step();
    chk("ex_full", 64'(a_valid), 64'd0);
    step();
    chk("ex_full2", 64'(a_valid), 64'd0);
    chk("ex_noready", 64'(trace_read_ready), 64'd0);
    d_valid = 4'b0001;
    d_source = 12'd5;
    #1;
    chk("ex_samecyc", 64'(a_valid), 64'd0);
    step();
    d_valid = '0;
    chk("ex_freed", 64'(a_valid), 64'h1);
    chk("ex_src5", 64'(a_source[2:0]), 64'd5);
    step();
    chk("ex_fetch9", 64'(trace_read_ready), 64'd1);

    // Stray response on lane 3, then reset mid-issue
    d_valid = 4'b1000;
    d_source = 12'(6 << 9);
    trace_read_valid = 4'b1000;
    set_lane(3, 64'h77, 64'h0, 1'b0, 8'd0);
    a_ready = 4'b0111;
    step();
    d_valid = '0;
    chk("bad_err", 64'(error), 64'd1);
    step();
    chk("bad_avalid", 64'(a_valid), 64'h8);
    chk("bad_src3", 64'(a_source[11:9]), 64'd0);
    chk("bad_sticky", 64'(error), 64'd1);
    reset = 1'b1;
    step();
    chk("mr_avalid", 64'(a_valid), 64'd0);
    chk("mr_err", 64'(error), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_cycle", trace_read_cycle, 64'd0);
    chk("mr_addr3", a_address[255:192], 64'd0);
    chk("mr_ready", 64'(trace_read_ready), 64'd0);

    // Finish with two outstanding lanes
    trace_read_valid = 4'b0011;
    set_lane(0, 64'h500, 64'h0, 1'b0, 8'd0);
    set_lane(1, 64'h600, 64'h0, 1'b0, 8'd0);
    a_ready = 4'hf;
    reset = 1'b0;
    #1;
    chk("f_ready", 64'(trace_read_ready), 64'd1);
    chk("f_cycle", trace_read_cycle, 64'd0);
    step();
    step();
    chk("f_avalid", 64'(a_valid), 64'h3);
    chk("f_src", 64'(a_source), 64'd0);
    step();
    chk("f_fetch", 64'(trace_read_ready), 64'd1);
    trace_read_valid = 4'b0000;
    trace_read_finished = 1'b1;
    step();
    step();
    chk("f_drain_rdy", 64'(trace_read_ready), 64'd0);
    chk("f_drain_done", 64'(done), 64'd0);
    step();
    chk("f_drain_done2", 64'(done), 64'd0);
    d_valid = 4'b0001;
    d_source = 12'd0;
    step();
    chk("f_one_left", 64'(done), 64'd0);
    d_valid = 4'b0010;
    d_source = 12'd0;
    #1;
    chk("f_pre_done", 64'(done), 64'd0);
    step();
    d_valid = '0;
    chk("f_done", 64'(done), 64'd1);
    chk("f_noerr", 64'(error), 64'd0);
    step();
    chk("f_done_sticky", 64'(done), 64'd1);
    chk("f_done_rdy", 64'(trace_read_ready), 64'd0);
    d_valid = 4'b0100;
    d_source = 12'(1 << 6);
    step();
    d_valid = '0;
    chk("f_late_err", 64'(error), 64'd1);
    chk("f_late_done", 64'(done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memtrace_lane_issuer.md
# memtrace_lane_issuer

Consumes the lane-parallel line stream of the simulation memory-trace reader and turns it into independent per-lane memory requests. Owns the reader's `trace_read_ready` / `trace_read_cycle` controls, buffers one trace line, issues each valid lane with a unique in-flight source ID, retires responses and reports completion. Sits directly downstream of the trace reader and upstream of the per-lane memory ports of the core-side harness.

## Interface
- `NUM_LANES`, 4: lanes per trace line.
- `DATA_WIDTH`, 64: address/data width per lane.
- `LOGSIZE_WIDTH`, 8: size field width per lane.
- `SOURCE_WIDTH`, 3: source ID width; at most 2^SOURCE_WIDTH requests in flight per lane.
- `clock`  in  1  single clock; everything rising-edge.
- `reset`  in  1  synchronous, active-high.
- `trace_read_cycle`  out  64  free-running cycle count to reader.
- `trace_read_ready`  out  1  reader may produce a new line at this edge.
- `trace_read_valid`  in  NUM_LANES  per-lane line valid from reader.
- `trace_read_address`, `trace_read_data`  in  DATA_WIDTH*NUM_LANES  per-lane fields.
- `trace_read_is_store`  in  NUM_LANES; `trace_read_size`  in  LOGSIZE_WIDTH*NUM_LANES.
- `trace_read_finished`  in  1  reader has no more lines.
- `a_valid` out NUM_LANES, `a_ready` in NUM_LANES: per-lane request handshake.
- `a_address`, `a_data` out DATA_WIDTH*NUM_LANES; `a_is_store` out NUM_LANES; `a_size` out LOGSIZE_WIDTH*NUM_LANES; `a_source` out SOURCE_WIDTH*NUM_LANES.
- `d_valid`  in  NUM_LANES; `d_source`  in  SOURCE_WIDTH*NUM_LANES: per-lane responses.
- `d_ready`  out  NUM_LANES  tied all-ones.
- `done`  out  1  trace finished and all responses returned; sticky.
- `error`  out  1  sticky: response with a source not in flight.

## Operation
- Reader updates its outputs at a posedge where `trace_read_ready`=1 and holds them otherwise; issuer therefore samples one cycle after a fetch.
- FSM states: FETCH, CAPTURE, ISSUE, DRAIN, DONE. Reset state FETCH.
- FETCH: `trace_read_ready`=1 for exactly one cycle -> CAPTURE.
- CAPTURE: `trace_read_ready`=0; latch all lane fields into line buffer, `pending` = `trace_read_valid`. If any valid -> ISSUE; else if `trace_read_finished` -> DRAIN; else -> FETCH.
- ISSUE: `a_valid[l]` = `pending[l]` AND lane l has a free source ID. Fields driven from buffer. On `a_valid[l]&a_ready[l]`: clear `pending[l]`, set in-flight bit of `a_source[l]`. Lanes independent; when `pending`==0 (including the cycle the last lane fires, evaluated on next-state) -> FETCH, or DRAIN if the buffered line carried `finished`.
- Source allocation: per-lane in-flight bitmap (2^SOURCE_WIDTH bits); `a_source[l]` = lowest clear bit of registered bitmap; stable while `a_valid[l]` held.
- Response: `d_valid[l]` clears bit `d_source[l]` of lane l. Bit already clear -> `error` set, bitmap unchanged.
- Same-cycle alloc and free on one lane: both applied; freed ID not offered until next cycle.
- DRAIN: no fetch; -> DONE when all bitmaps zero. DONE: `done`=1, absorbing until reset; responses still retired, late stray ones flag `error`.
- Reset (any state, mid-issue included): buffer, pending, bitmaps, counter, `done`, `error` cleared; state FETCH; in-flight requests forgotten.

## Timing
- Reset values: `trace_read_ready`=0 during reset, 1 in first post-reset cycle (FETCH); `trace_read_cycle`=0; `a_valid`=0; `a_*` fields 0; `done`=0; `error`=0; `d_ready`=all ones.
- `trace_read_cycle` increments by 1 every non-reset cycle; 64-bit wrap unhandled.
- Fetch-to-first-`a_valid`: 2 cycles (FETCH, CAPTURE, then ISSUE). Minimum line period: 3 cycles.
- `a_valid` may not drop without `a_ready`; fields stable while held.
- Lane with full bitmap holds `a_valid`=0; others proceed.
- `done` rises the cycle after the last in-flight bit clears in DRAIN.

## Test plan
- Single line, lanes 0,2 valid, `a_ready`=1: `trace_read_ready` high cycle 1 after reset, `a_valid`=4'b0101 cycle 3, `a_source`=0 both lanes; next FETCH cycle 4.
- Back-pressure: lane 1 `a_ready`=0 for 5 cycles -> lane 1 `a_valid` and fields stable, no FETCH until lane 1 fires.
- Source exhaustion, SOURCE_WIDTH=3: 9 lane-0 lines, no responses -> sources 0..7 issued, 9th held; `d_source`=5 -> 9th issues with source 5 next cycle.
- Finish: `finished`=1 with empty line, 2 outstanding -> DRAIN, `done` rises one cycle after second response.
- Bad response: `d_valid[3]`, `d_source`=6 never issued -> `error`=1 sticky, bitmaps unchanged.
- Reset asserted mid-ISSUE -> next cycle all outputs at reset values; FETCH resumes, `trace_read_cycle` restarts at 0.
